// File: rtl/pc_branch_unit.sv
// pc_branch_unit: program counter with conditional branch resolution, a RUN/HALT
// state machine and saturating branch statistics counters.
module pc_branch_unit #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned OFFSET_W = 9,
  parameter int unsigned INC      = 2,
  parameter int unsigned SHIFT    = 1,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_valid,
  input  logic                br_reg,
  input  logic [2:0]          cond,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [2:0]          flags,
  input  logic [WIDTH-1:0]    rs_val,
  input  logic                halt,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_seq,
  output logic                taken,
  output logic                flush,
  output logic                halted,
  output logic [CNT_W-1:0]    br_cnt,
  output logic [CNT_W-1:0]    taken_cnt
);

  typedef enum logic {
    StRun,
    StHalt
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             r_flush;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_flag_n;
  logic             w_flag_v;
  logic             w_flag_z;
  logic             w_cond_true;
  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_off_ext;
  logic [WIDTH-1:0] w_rel_target;
  logic [WIDTH-1:0] w_target;
  logic             w_br_accept;
  logic             w_taken;

  assign w_flag_n = flags[2];
  assign w_flag_v = flags[1];
  assign w_flag_z = flags[0];

  // Sequential address and PC-relative target; both wrap silently modulo 2^WIDTH.
  assign w_pc_seq     = r_pc + WIDTH'(INC);
  assign w_off_ext    = WIDTH'($signed(offset));
  assign w_rel_target = w_pc_seq + (w_off_ext << SHIFT);
  assign w_target     = br_reg ? rs_val : w_rel_target;

  // Decode the branch condition code against the {N,V,Z} flags.
  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000:  w_cond_true = !w_flag_z;
      3'b001:  w_cond_true = w_flag_z;
      3'b010:  w_cond_true = !w_flag_z && !w_flag_n;
      3'b011:  w_cond_true = w_flag_n;
      3'b100:  w_cond_true = w_flag_z || (!w_flag_z && !w_flag_n);
      3'b101:  w_cond_true = w_flag_z || w_flag_n;
      3'b110:  w_cond_true = w_flag_v;
      default: w_cond_true = 1'b1;
    endcase
  end

  // Next state, next PC and branch acceptance; halt outranks a simultaneous branch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_br_accept = 1'b0;
    w_taken     = 1'b0;
    case (r_state)
      StRun: begin
        if (!stall) begin
          if (halt) begin
            w_state_nxt = StHalt;
          end else if (br_valid) begin
            w_br_accept = 1'b1;
            if (w_cond_true) begin
              w_taken  = 1'b1;
              w_pc_nxt = w_target;
            end else begin
              w_pc_nxt = w_pc_seq;
            end
          end else begin
            w_pc_nxt = w_pc_seq;
          end
        end
      end
      StHalt: begin
        // Everything frozen; only reset leaves this state.
        w_state_nxt = StHalt;
      end
      default: begin
        w_state_nxt = StRun;
      end
    endcase
  end

  // State register with asynchronous reset back to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC register and the one-cycle flush pulse that follows a taken branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= WIDTH'(RESET_PC);
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_flush <= w_taken;
    end
  end

  // Saturating statistics counters for accepted and taken branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else begin
      if (w_br_accept && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      end
      if (w_taken && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign pc        = r_pc;
  assign pc_seq    = w_pc_seq;
  assign taken     = w_taken;
  assign flush     = r_flush;
  assign halted    = (r_state == StHalt);
  assign br_cnt    = r_br_cnt;
  assign taken_cnt = r_taken_cnt;

endmodule
